// File: rtl/mem_access_responder.sv
// Line-granular memory access responder: queues cache requests, issues them in order to a
// line-wide backend and returns serial-tagged read data and write completions.
// Optional statistics outputs are enabled by defining MEM_ACCESS_RESPONDER_STATS_EN.
module mem_access_responder #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned LINE_WIDTH      = 128,
   parameter int unsigned RSERIAL_WIDTH   = 2,
   parameter int unsigned WSERIAL_WIDTH   = 1,
   parameter int unsigned REQ_QUEUE_DEPTH = 4,
   parameter int unsigned RD_TAG_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reqValid,
   input  logic                     reqWE,
   input  logic [ADDR_WIDTH-1:0]    reqAddr,
   input  logic [LINE_WIDTH-1:0]    reqData,
   output logic                     reqAck,
   output logic [RSERIAL_WIDTH-1:0] reqSerial,
   output logic [WSERIAL_WIDTH-1:0] reqWSerial,
   output logic                     resultValid,
   output logic [RSERIAL_WIDTH-1:0] resultSerial,
   output logic [LINE_WIDTH-1:0]    resultData,
   output logic                     responseValid,
   output logic [WSERIAL_WIDTH-1:0] responseSerial,
   output logic                     memValid,
   output logic                     memWE,
   output logic [ADDR_WIDTH-1:0]    memAddr,
   output logic [LINE_WIDTH-1:0]    memWData,
   input  logic                     memReady,
   input  logic                     memRspValid,
   input  logic [LINE_WIDTH-1:0]    memRspData
`ifdef MEM_ACCESS_RESPONDER_STATS_EN
   ,
   output logic [31:0]                        statReadCount,
   output logic [31:0]                        statWriteCount,
   output logic [$clog2(REQ_QUEUE_DEPTH):0]   statMaxOccupancy,
   output logic                               statOrphanRsp
`endif
);

   localparam int unsigned QAW = $clog2(REQ_QUEUE_DEPTH);
   localparam int unsigned TAW = $clog2(RD_TAG_DEPTH);
   localparam logic [QAW:0] QFullCount = (QAW+1)'(REQ_QUEUE_DEPTH);
   localparam logic [TAW:0] TFullCount = (TAW+1)'(RD_TAG_DEPTH);

   // Request queue
   logic [REQ_QUEUE_DEPTH-1:0] qWE;
   logic [ADDR_WIDTH-1:0]      qAddr    [REQ_QUEUE_DEPTH];
   logic [LINE_WIDTH-1:0]      qData    [REQ_QUEUE_DEPTH];
   logic [RSERIAL_WIDTH-1:0]   qRSerial [REQ_QUEUE_DEPTH];
   logic [WSERIAL_WIDTH-1:0]   qWSerial [REQ_QUEUE_DEPTH];
   logic [QAW-1:0]             qHead, qTail;
   logic [QAW:0]               qCount, qCountNext;

   // Read-tag FIFO: serials of reads issued to the backend, in issue order
   logic [RSERIAL_WIDTH-1:0]   tSerial [RD_TAG_DEPTH];
   logic [TAW-1:0]             tHead, tTail;
   logic [TAW:0]               tCount, tCountNext;

   logic [RSERIAL_WIDTH-1:0]   rdSerialCnt;
   logic [WSERIAL_WIDTH-1:0]   wrSerialCnt;

   logic qPush, qPop, qEmpty, qFull, headWE;
   logic tagPush, tagPop, tagEmpty, tagFull;

   assign qEmpty   = (qCount == '0);
   assign qFull    = (qCount == QFullCount);
   assign tagEmpty = (tCount == '0);
   assign tagFull  = (tCount == TFullCount);
   assign headWE   = qWE[qHead];

   assign reqAck     = reqValid && !qFull;
   assign reqSerial  = rdSerialCnt;
   assign reqWSerial = wrSerialCnt;
   assign qPush      = reqAck;

   // A tag slot freed by this cycle's backend response can be reused by this cycle's read issue
   assign tagPop   = memRspValid && !tagEmpty;
   assign memValid = !qEmpty && (headWE || !tagFull || tagPop);
   assign memWE    = headWE;
   assign memAddr  = qAddr[qHead];
   assign memWData = qData[qHead];
   assign qPop     = memValid && memReady;
   assign tagPush  = qPop && !headWE;

   always_comb begin
      qCountNext = qCount;
      if (qPush && !qPop) begin
         qCountNext = qCount + 1'b1;
      end else if (!qPush && qPop) begin
         qCountNext = qCount - 1'b1;
      end
   end

   always_comb begin
      tCountNext = tCount;
      if (tagPush && !tagPop) begin
         tCountNext = tCount + 1'b1;
      end else if (!tagPush && tagPop) begin
         tCountNext = tCount - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qHead       <= '0;
         qTail       <= '0;
         qCount      <= '0;
         tHead       <= '0;
         tTail       <= '0;
         tCount      <= '0;
         rdSerialCnt <= '0;
         wrSerialCnt <= '0;
      end else begin
         qCount <= qCountNext;
         tCount <= tCountNext;
         if (qPush) begin
            qTail <= qTail + 1'b1;
            if (reqWE) begin
               wrSerialCnt <= wrSerialCnt + 1'b1;
            end else begin
               rdSerialCnt <= rdSerialCnt + 1'b1;
            end
         end
         if (qPop) begin
            qHead <= qHead + 1'b1;
         end
         if (tagPush) begin
            tTail <= tTail + 1'b1;
         end
         if (tagPop) begin
            tHead <= tHead + 1'b1;
         end
      end
   end

   // Storage is cleared too so the head-driven mem* outputs read 0 out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qWE <= '0;
         for (int unsigned i = 0; i < REQ_QUEUE_DEPTH; i++) begin
            qAddr[i]    <= '0;
            qData[i]    <= '0;
            qRSerial[i] <= '0;
            qWSerial[i] <= '0;
         end
         for (int unsigned i = 0; i < RD_TAG_DEPTH; i++) begin
            tSerial[i] <= '0;
         end
      end else begin
         if (qPush) begin
            qWE[qTail]      <= reqWE;
            qAddr[qTail]    <= reqAddr;
            qData[qTail]    <= reqData;
            qRSerial[qTail] <= rdSerialCnt;
            qWSerial[qTail] <= wrSerialCnt;
         end
         if (tagPush) begin
            tSerial[tTail] <= qRSerial[qHead];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resultValid    <= 1'b0;
         resultSerial   <= '0;
         resultData     <= '0;
         responseValid  <= 1'b0;
         responseSerial <= '0;
      end else begin
         resultValid   <= tagPop;
         responseValid <= qPop && headWE;
         if (tagPop) begin
            resultSerial <= tSerial[tHead];
            resultData   <= memRspData;
         end
         if (qPop && headWE) begin
            responseSerial <= qWSerial[qHead];
         end
      end
   end

`ifdef MEM_ACCESS_RESPONDER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         statReadCount    <= '0;
         statWriteCount   <= '0;
         statMaxOccupancy <= '0;
         statOrphanRsp    <= 1'b0;
      end else begin
         if (qPush && !reqWE && (statReadCount != '1)) begin
            statReadCount <= statReadCount + 1'b1;
         end
         if (qPush && reqWE && (statWriteCount != '1)) begin
            statWriteCount <= statWriteCount + 1'b1;
         end
         if (qCountNext > statMaxOccupancy) begin
            statMaxOccupancy <= qCountNext;
         end
         if (memRspValid && tagEmpty) begin
            statOrphanRsp <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Memory-side responder for the cache system's line-granular memory access protocol: accepts read/write requests from the I/D-cache arbiter, acks them with serials, and returns read data and write completions tagged with those serials.
- Sits between the memory-access arbiter and a line-wide backend RAM/controller port.
- Buffers accepted requests and tracks outstanding reads, so MSHRs can keep several transactions in flight.

Parameters:
- ADDR_WIDTH, 32, physical address width (PHY_ADDR_WIDTH).
- LINE_WIDTH, 128, line data width in bits (DCACHE_LINE_BIT_WIDTH).
- RSERIAL_WIDTH, 2, read serial width (MEM_ACCESS_SERIAL_BIT_SIZE).
- WSERIAL_WIDTH, 1, write serial width (MEM_WRITE_SERIAL_BIT_SIZE).
- REQ_QUEUE_DEPTH, 4, accepted-but-unissued request entries; power of two, at least 2.
- RD_TAG_DEPTH, 4, maximum reads outstanding at the backend; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- reqValid  in  1  request valid
- reqWE  in  1  1 = write, 0 = read
- reqAddr  in  ADDR_WIDTH  line-aligned address
- reqData  in  LINE_WIDTH  write data
- reqAck  out  1  request accepted this cycle
- reqSerial  out  RSERIAL_WIDTH  serial assigned to an accepted read
- reqWSerial  out  WSERIAL_WIDTH  serial assigned to an accepted write
- resultValid  out  1  read data valid
- resultSerial  out  RSERIAL_WIDTH  serial of the returned read
- resultData  out  LINE_WIDTH  read line data
- responseValid  out  1  write completion valid
- responseSerial  out  WSERIAL_WIDTH  serial of the completed write
- memValid  out  1  backend request valid
- memWE  out  1  backend write enable
- memAddr  out  ADDR_WIDTH  backend address
- memWData  out  LINE_WIDTH  backend write data
- memReady  in  1  backend accepts the request this cycle
- memRspValid  in  1  backend read data valid; read data returns in issue order
- memRspData  in  LINE_WIDTH  backend read data

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - All outputs are 0.
  - Request queue, read-tag FIFO, read serial counter and write serial counter are cleared.
- Accept (combinational):
  - reqAck = reqValid && !reqQueueFull.
  - reqSerial always shows the current read counter; reqWSerial always shows the current write counter.
  - On an accept, the request is pushed with its serial and the matching counter increments modulo 2^width. Counters wrap with no check.
  - The initiator owns serial uniqueness: at most 2^RSERIAL_WIDTH reads and 2^WSERIAL_WIDTH writes outstanding.
  - With reqAck=0 nothing is stored; the initiator holds its request and retries.
- Issue:
  - memValid = queue non-empty && (head is a write || readTagFIFO not full).
  - mem* outputs are driven from the queue head.
  - A handshake (memValid && memReady) pops the head.
  - A read issue pushes its serial into the read-tag FIFO.
  - A write issue registers responseValid=1 and responseSerial = the write's serial on the next cycle, held for exactly one cycle.
- Read return:
  - memRspValid pops the read-tag FIFO head.
  - On the next cycle: resultValid=1, resultSerial = popped serial, resultData = memRspData, held for one cycle.
  - memRspValid with an empty read-tag FIFO is ignored: no result, no state change.
- Latency: with memReady=1 and an immediate backend,
  - write response appears 2 cycles after reqAck;
  - read result appears 1 cycle after memRspValid.
- Simultaneous events:
  - Push and pop on the same cycle are allowed in both queues. A push on a full request queue is impossible, because reqAck=0 when full.
  - A read pop from the tag FIFO and a new read issue in the same cycle are both honoured, even when the FIFO is full.
  - resultValid and responseValid may both be 1 in the same cycle; they are independent channels.
- Ordering: strict in-order issue; no read/write reordering or bypass. Same-address read-after-write coherence follows from in-order issue.
- Reset mid-operation: all queued and outstanding transactions are discarded. Backend responses arriving after reset are ignored because the FIFO is empty.

Optional Feature:
- Macro: MEM_ACCESS_RESPONDER_STATS_EN.
- When defined, adds these outputs, all cleared by rst and saturating at all-ones:
  - statReadCount (32 bits): accepted reads.
  - statWriteCount (32 bits): accepted writes.
  - statMaxOccupancy ($clog2(REQ_QUEUE_DEPTH)+1 bits): peak request-queue occupancy.
  - statOrphanRsp (1 bit, sticky): set when memRspValid arrives with an empty tag FIFO.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then single read: reqValid, reqWE=0, addr 0x1000, memReady=1 → reqAck=1, reqSerial=0, memValid next cycle with memAddr=0x1000. Then memRspValid with data 0xA5…A5 → one cycle later resultValid=1, resultSerial=0, resultData=0xA5…A5.
- Write: reqWE=1, addr 0x2040 → reqAck=1, reqWSerial=0; responseValid=1, responseSerial=0 two cycles after ack. A second write gets serial 1, a third wraps to 0.
- Backpressure: memReady=0 while issuing 5 requests → the first 4 ack, the 5th sees reqAck=0. Raising memReady drains the queue in order and re-enables reqAck.
- Read-tag limit: 5 reads with memReady=1 and no memRspValid → the 5th is held (memValid=0). One memRspValid lets it issue that same cycle; results return with serials 0,1,2,3 in order.
- Mixed traffic: read, write, read with backend read latency of 3 → responseValid and resultValid overlap on one cycle with correct serials; results carry serials 0 and 1.
- Reset mid-operation: rst asserted with 2 reads outstanding, then memRspValid pulses → no resultValid. The next accepted read gets serial 0.
